// File: rtl/cordic_scheduler.sv
// Round-robin scheduler that time-shares one iterative CORDIC rotation core between two requesters.
// Optional quadrant folding of the angle is enabled by defining CORDIC_QUAD_FOLD_EN.
module cordic_scheduler #(
   parameter int             W      = 17,
   parameter int             ITER   = 16,
   parameter logic [W-1:0]   X_INIT = W'(19896)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_theta,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_theta,
   output logic         req1_ready,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_x,
   output logic [W-1:0] rsp_y,
   output logic         busy,
   output logic         cor_rst,
   output logic [W-1:0] cor_x_i,
   output logic [W-1:0] cor_y_i,
   output logic [W-1:0] cor_theta_i,
   input  logic [W-1:0] cor_x_o,
   input  logic [W-1:0] cor_y_o,
   input  logic [W-1:0] cor_theta_o
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_last_grant;
   logic            r_id;
   logic [W-1:0]    r_theta;
   logic [W-1:0]    r_cor_x;
   logic [CW-1:0]   r_iter_cnt;
   logic            r_rsp_id;
   logic [W-1:0]    r_rsp_x;
   logic [W-1:0]    r_rsp_y;
   logic            w_grant;
   logic            w_grant_id;
   logic [W-1:0]    w_theta_sel;
   logic [W-1:0]    w_theta_core;
   logic            w_last_iter;
   logic            w_unused;

   assign w_unused    = ^cor_theta_o;
   assign w_last_iter = (r_iter_cnt == CW'(ITER - 1));
   assign w_theta_sel = w_grant_id ? req1_theta : req0_theta;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next     = r_state;
      w_grant    = 1'b0;
      w_grant_id = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_grant    = req0_valid | req1_valid;
            w_grant_id = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
            if (w_grant) begin
               req0_ready = ~w_grant_id;
               req1_ready = w_grant_id;
               w_next     = S_LOAD;
            end
         end
         S_LOAD:  w_next = S_RUN;
         S_RUN:   if (w_last_iter) w_next = S_DONE;
         S_DONE:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

`ifdef CORDIC_QUAD_FOLD_EN
   localparam logic signed [W-1:0] DEG90  = W'(23040);
   localparam logic signed [W-1:0] DEG180 = W'(46080);

   logic w_fold;
   logic r_fold;

   // Angles beyond +/-90 deg are rotated by 180 deg; the result is negated at capture.
   always_comb begin
      w_fold       = 1'b0;
      w_theta_core = w_theta_sel;
      if ($signed(w_theta_sel) > DEG90) begin
         w_fold       = 1'b1;
         w_theta_core = w_theta_sel - DEG180;
      end else if ($signed(w_theta_sel) < -DEG90) begin
         w_fold       = 1'b1;
         w_theta_core = w_theta_sel + DEG180;
      end
   end
`else
   assign w_theta_core = w_theta_sel;
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_theta      <= '0;
         r_cor_x      <= '0;
         r_iter_cnt   <= '0;
         r_rsp_id     <= 1'b0;
         r_rsp_x      <= '0;
         r_rsp_y      <= '0;
`ifdef CORDIC_QUAD_FOLD_EN
         r_fold       <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_theta      <= w_theta_core;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_cor_x      <= X_INIT;
`ifdef CORDIC_QUAD_FOLD_EN
            r_fold       <= w_fold;
`endif
         end
         if (r_state == S_LOAD) r_iter_cnt <= '0;
         if (r_state == S_RUN) begin
            r_iter_cnt <= r_iter_cnt + 1'b1;
            if (w_last_iter) begin
               r_rsp_id <= r_id;
`ifdef CORDIC_QUAD_FOLD_EN
               r_rsp_x  <= r_fold ? ('0 - cor_x_o) : cor_x_o;
               r_rsp_y  <= r_fold ? ('0 - cor_y_o) : cor_y_o;
`else
               r_rsp_x  <= cor_x_o;
               r_rsp_y  <= cor_y_o;
`endif
            end
         end
      end
   end

   assign rsp_valid   = (r_state == S_DONE);
   assign busy        = (r_state != S_IDLE);
   assign rsp_id      = r_rsp_id;
   assign rsp_x       = r_rsp_x;
   assign rsp_y       = r_rsp_y;
   assign cor_rst     = (r_state != S_RUN);
   assign cor_x_i     = r_cor_x;
   assign cor_y_i     = '0;
   assign cor_theta_i = r_theta;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Self-checking bench for cordic_scheduler with a behavioural iterative CORDIC core and a result scoreboard.
// Define CORDIC_QUAD_FOLD_EN for both files to exercise the folded-angle cases.
module tb_cordic_scheduler;

   localparam int  W    = 17;
   localparam int  ITER = 16;
   localparam real PI   = 3.14159265358979;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req1_valid;
   logic [W-1:0] req0_theta, req1_theta;
   logic         req0_ready, req1_ready;
   logic         rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0] rsp_x, rsp_y;
   logic         busy, cor_rst;
   logic [W-1:0] cor_x_i, cor_y_i, cor_theta_i;
   logic [W-1:0] cor_x_o, cor_y_o, cor_theta_o;

   cordic_scheduler #(.W(W), .ITER(ITER)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_theta(req0_theta), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_theta(req1_theta), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_x(rsp_x), .rsp_y(rsp_y), .busy(busy),
      .cor_rst(cor_rst), .cor_x_i(cor_x_i), .cor_y_i(cor_y_i), .cor_theta_i(cor_theta_i),
      .cor_x_o(cor_x_o), .cor_y_o(cor_y_o), .cor_theta_o(cor_theta_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input int obs, input int exp, input int tol);
      int diff;
      diff = obs - exp;
      n_cmp++;
      if (diff > tol || diff < -tol) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
      end
   endtask

   // Core model: x/y inputs are Q1.15 (X_INIT = 0.6073), angles Q8.8 degrees, outputs Q8.8.
   int atan_tab [0:31];
   int cx, cy, cz, ci;

   initial begin
      for (int i = 0; i < 32; i++)
         atan_tab[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 180.0 / PI * 256.0 + 0.5);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cx <= 0; cy <= 0; cz <= 0; ci <= 0;
      end else if (cor_rst) begin
         cx <= int'($signed(cor_x_i));
         cy <= int'($signed(cor_y_i));
         cz <= int'($signed(cor_theta_i));
         ci <= 0;
      end else if (ci < ITER) begin
         if (cz >= 0) begin
            cx <= cx - (cy >>> ci);
            cy <= cy + (cx >>> ci);
            cz <= cz - atan_tab[ci];
         end else begin
            cx <= cx + (cy >>> ci);
            cy <= cy - (cx >>> ci);
            cz <= cz + atan_tab[ci];
         end
         ci <= ci + 1;
      end
   end

   assign cor_x_o     = W'((cx + 64) >>> 7);
   assign cor_y_o     = W'((cy + 64) >>> 7);
   assign cor_theta_o = W'(cz);

   function automatic logic [W-1:0] to_th(input real deg);
      return W'($rtoi(deg * 256.0));
   endfunction

   function automatic int ref_val(input logic [W-1:0] th, input bit want_sin);
      real r;
      r = real'(int'($signed(th))) / 256.0 * PI / 180.0;
      return $rtoi($floor(256.0 * (want_sin ? $sin(r) : $cos(r)) + 0.5));
   endfunction

   function automatic int core_theta(input logic [W-1:0] th);
      int t;
      t = int'($signed(th));
`ifdef CORDIC_QUAD_FOLD_EN
      if (t > 23040) t -= 46080;
      else if (t < -23040) t += 46080;
`endif
      return t;
   endfunction

   typedef struct {
      bit id;
      int x;
      int y;
   } exp_t;

   exp_t sb [$];
   bit   grant_log [$];
   int   cyc = 0;
   int   n_grant = 0;
   int   t_acc = 0;
   int   m_theta = 0;
   bit   m_last = 1'b1;
   bit   pend_load = 1'b0;
   bit   prev_valid = 1'b0;
   bit   gid;
   exp_t e;
   logic [W-1:0] th;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: protocol rules, grant model, LOAD contents, latency and scoreboard compare.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         m_last     = 1'b1;
         pend_load  = 1'b0;
         prev_valid = 1'b0;
      end else begin
         check("dual_ready", int'(req0_ready && req1_ready), 0, 0);
         if (busy) check("ready_while_busy", int'(req0_ready || req1_ready), 0, 0);
         if (pend_load) begin
            check("load_cor_rst", int'(cor_rst), 1, 0);
            check("load_x_i", int'(cor_x_i), 19896, 0);
            check("load_y_i", int'(cor_y_i), 0, 0);
            check("load_theta_i", int'($signed(cor_theta_i)), m_theta, 0);
            pend_load = 1'b0;
         end
         if (req0_ready || req1_ready) begin
            gid = req1_ready;
            th  = gid ? req1_theta : req0_theta;
            if (req0_valid && req1_valid) check("rr_tie", int'(gid), int'(!m_last), 0);
            m_last = gid;
            grant_log.push_back(gid);
            n_grant++;
            t_acc     = cyc;
            m_theta   = core_theta(th);
            e.id      = gid;
            e.x       = ref_val(th, 1'b0);
            e.y       = ref_val(th, 1'b1);
            sb.push_back(e);
            pend_load = 1'b1;
         end
         if (rsp_valid && !prev_valid) check("latency", cyc - t_acc, ITER + 2, 0);
         prev_valid = rsp_valid;
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", sb.size(), 1, 0);
            end else begin
               e = sb.pop_front();
               check("rsp_id", int'(rsp_id), int'(e.id), 0);
               check("rsp_x", int'($signed(rsp_x)), e.x, 2);
               check("rsp_y", int'($signed(rsp_y)), e.y, 2);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit id, input logic [W-1:0] theta);
      int g0;
      g0 = n_grant;
      if (id) begin req1_theta = theta; req1_valid = 1'b1; end
      else    begin req0_theta = theta; req0_valid = 1'b1; end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (n_grant != g0) break;
      end
      if (n_grant == g0) check("grant_timeout", n_grant - g0, 1, 0);
      tick();
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!busy && !rsp_valid && sb.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("drain_timeout", sb.size() + int'(busy), 0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
      $fatal(1, "watchdog expired");
   end

   real          angs [6] = '{45.0, 0.0, 90.0, -45.0, -90.0, 30.0};
   int           base;
   logic [W-1:0] cap_x, cap_y;
   logic         cap_id;

   initial begin
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_theta = '0;
      req1_theta = '0;
      rsp_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req0_ready", int'(req0_ready), 0, 0);
      check("rst_req1_ready", int'(req1_ready), 0, 0);
      check("rst_rsp_valid", int'(rsp_valid), 0, 0);
      check("rst_rsp_id", int'(rsp_id), 0, 0);
      check("rst_rsp_x", int'(rsp_x), 0, 0);
      check("rst_rsp_y", int'(rsp_y), 0, 0);
      check("rst_busy", int'(busy), 0, 0);
      check("rst_cor_rst", int'(cor_rst), 1, 0);
      check("rst_cor_x_i", int'(cor_x_i), 0, 0);
      check("rst_cor_theta_i", int'(cor_theta_i), 0, 0);
      rst_n = 1'b1;
      tick();

      // Single requests across the convergence range, alternating requesters.
      for (int k = 0; k < 6; k++) begin
         send(k[0], to_th(angs[k]));
         drain();
      end

      // Both requesters held valid: grants must alternate starting with requester 0.
      base       = grant_log.size();
      req0_theta = to_th(60.0);
      req1_theta = to_th(-30.0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (n_grant >= base + 4) break;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("tie_grants", grant_log.size() - base, 4, 0);
      for (int k = 0; k < 4; k++)
         if (base + k < grant_log.size()) check("tie_seq", int'(grant_log[base + k]), k % 2, 0);
      drain();

      // Backpressure in DONE with a competing request pending.
      rsp_ready = 1'b0;
      send(1'b0, to_th(20.0));
      req1_theta = to_th(10.0);
      req1_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (rsp_valid) break;
         tick();
      end
      check("bp_valid", int'(rsp_valid), 1, 0);
      cap_x  = rsp_x;
      cap_y  = rsp_y;
      cap_id = rsp_id;
      check("bp_x_model", int'($signed(cap_x)), ref_val(to_th(20.0), 1'b0), 2);
      check("bp_id_model", int'(cap_id), 0, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_hold_valid", int'(rsp_valid), 1, 0);
         check("bp_hold_x", int'(rsp_x), int'(cap_x), 0);
         check("bp_hold_y", int'(rsp_y), int'(cap_y), 0);
         check("bp_hold_id", int'(rsp_id), int'(cap_id), 0);
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_release_valid", int'(rsp_valid), 0, 0);
      check("bp_release_busy", int'(busy), 0, 0);
      base = n_grant;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (n_grant != base) break;
      end
      check("bp_next_grant", n_grant - base, 1, 0);
      tick();
      req1_valid = 1'b0;
      drain();

      // Reset five cycles after an accept aborts the request.
      base       = n_grant;
      req0_theta = to_th(60.0);
      req0_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (n_grant != base) break;
      end
      tick();
      req0_valid = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_busy", int'(busy), 0, 0);
      check("midrst_rsp_valid", int'(rsp_valid), 0, 0);
      check("midrst_cor_rst", int'(cor_rst), 1, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      send(1'b1, to_th(-60.0));
      drain();

`ifdef CORDIC_QUAD_FOLD_EN
      send(1'b0, to_th(180.0));
      drain();
      send(1'b1, to_th(-135.0));
      drain();
      send(1'b0, to_th(120.0));
      drain();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
